// File: rtl/z80_bus_ctrl.sv
// Z80 bus controller: decodes slave windows, drives one-hot enables and the read mux, and inserts wait states.
// Latency: enables and read data are combinational; wait_n drops in the start cycle; flags update one cycle after the event.
// Backpressure: slv_rdy low holds wait_n low; hung accesses are aborted after TIMEOUT low cycles.
//
// Ports: masterclk/reset_n (sync, active low); CPU side addr, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
//        wait_n, cpu_di, inta; slave side slv_rdy, slv_dout, slv_ena, slv_sel; status bus_err,
//        err_unmapped, err_addr, with err_clr to clear the sticky flags.
module z80_bus_ctrl #(
    parameter int                    NSLAVES  = 4,
    parameter logic [16*NSLAVES-1:0] SLV_BASE = '0,
    parameter logic [16*NSLAVES-1:0] SLV_MASK = '0,
    parameter logic [NSLAVES-1:0]    SLV_IO   = '0,
    parameter logic [4*NSLAVES-1:0]  SLV_WAIT = '0,
    parameter logic [7:0]            OPEN_BUS = 8'hFF,
    parameter int                    TIMEOUT  = 255,
    localparam int                   SELW     = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
    input  logic                   masterclk,
    input  logic                   reset_n,
    input  logic [15:0]            addr,
    input  logic                   mreq_n,
    input  logic                   iorq_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic                   m1_n,
    input  logic                   rfsh_n,
    input  logic [NSLAVES-1:0]     slv_rdy,
    input  logic [8*NSLAVES-1:0]   slv_dout,
    input  logic                   err_clr,
    output logic                   wait_n,
    output logic [7:0]             cpu_di,
    output logic [NSLAVES-1:0]     slv_ena,
    output logic [SELW-1:0]        slv_sel,
    output logic                   inta,
    output logic                   bus_err,
    output logic                   err_unmapped,
    output logic [15:0]            err_addr
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [7:0]        tcnt, tcnt_nxt;
    logic              abort, abort_nxt;
    logic              unm_set, tmo_set;

    logic              mem_cyc, io_cyc, start;
    logic [NSLAVES-1:0] hit;
    logic              hit_any;
    logic [SELW-1:0]   sel;
    logic [3:0]        sel_wait;
    logic              sel_rdy;
    logic [7:0]        sel_dout;

    // Refresh cycles also pull mreq_n low, and INTA pulls iorq_n low with m1_n; both are excluded.
    assign mem_cyc = ~mreq_n & rfsh_n;
    assign io_cyc  = ~iorq_n & m1_n;
    assign inta    = ~m1_n & ~iorq_n;
    assign start   = (state == S_IDLE) && (mem_cyc || io_cyc) && (!rd_n || !wr_n);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            hit[i] = (SLV_IO[i] ? io_cyc : mem_cyc) &&
                     ((addr & SLV_MASK[16*i +: 16]) == (SLV_BASE[16*i +: 16] & SLV_MASK[16*i +: 16]));
        end
    end

    // Scan from the top so the lowest-indexed hit is the last one written.
    always_comb begin
        hit_any = 1'b0;
        sel     = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                sel     = SELW'(i);
            end
        end
    end

    always_comb begin
        slv_ena = '0;
        if (hit_any) slv_ena[sel] = 1'b1;
    end

    assign slv_sel  = sel;
    assign sel_wait = SLV_WAIT[4*sel +: 4];
    assign sel_rdy  = slv_rdy[sel];
    assign sel_dout = slv_dout[8*sel +: 8];

    // The start cycle is itself the first low wait_n cycle, so cnt holds the waits still owed after
    // it and tcnt starts at 1. The exit cycle releases wait_n combinationally.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tcnt_nxt  = tcnt;
        abort_nxt = abort;
        wait_n    = 1'b1;
        unm_set   = 1'b0;
        tmo_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!hit_any) begin
                        unm_set   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt  = (sel_wait == 4'd0) ? 4'd0 : sel_wait - 4'd1;
                        tcnt_nxt = 8'd1;
                        if (sel_wait != 4'd0 || !sel_rdy) begin
                            wait_n    = 1'b0;
                            state_nxt = S_WAIT;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0 && sel_rdy) begin
                    state_nxt = S_DONE;
                end else if (tcnt == TMO) begin
                    tmo_set   = 1'b1;
                    abort_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    wait_n   = 1'b0;
                    tcnt_nxt = tcnt + 8'd1;
                    if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                end
            end
            S_DONE: begin
                if (rd_n && wr_n) begin
                    state_nxt = S_IDLE;
                    abort_nxt = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!reset_n) wait_n = 1'b1;
    end

    // An aborted access must not hand the CPU whatever the hung slave is driving.
    always_comb begin
        cpu_di = OPEN_BUS;
        if (!(abort || tmo_set) && hit_any && !rd_n) cpu_di = sel_dout;
    end

    always_ff @(posedge masterclk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            tcnt         <= 8'd0;
            abort        <= 1'b0;
            bus_err      <= 1'b0;
            err_unmapped <= 1'b0;
            err_addr     <= 16'h0000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tcnt  <= tcnt_nxt;
            abort <= abort_nxt;
            // A fresh error beats a simultaneous clear.
            if (tmo_set)       bus_err <= 1'b1;
            else if (err_clr)  bus_err <= 1'b0;
            if (unm_set)       err_unmapped <= 1'b1;
            else if (err_clr)  err_unmapped <= 1'b0;
            if (tmo_set || unm_set) err_addr <= addr;
        end
    end

endmodule
